// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type, geometry helpers and byte parity for sram_sp_param.
package sram_pkg;
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;
  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
  function automatic logic parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/sram_init_fsm.sv
// sram_init_fsm: post-reset clear sequencer, sweeps every address once then enters READY.
module sram_init_fsm #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);
  import sram_pkg::*;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= ST_READY;
    end
  end
  assign init_busy = (state == ST_INIT);
  assign clr_we    = init_busy;
  assign clr_addr  = cnt;
endmodule

// File: rtl/sram_sp_param.sv
// sram_sp_param: single-port SRAM with byte enables, registered read and post-reset clear.
// Optional per-lane even parity when SRAM_PARITY_EN is defined.
module sram_sp_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 11,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   d,
  input  logic                par_inj,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                par_err,
  output logic                init_busy
);
  import sram_pkg::*;
  localparam int NUM_LANES = lanes_of(DATA_W);
  localparam int DEPTH     = depth_of(ADDR_W);
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]    clr_addr, wa;
  logic                 clr_we, acc;
  logic [NUM_LANES-1:0] wl;
  logic [DATA_W-1:0]    wd, rd_old, rd_word;
  sram_init_fsm #(.ADDR_W(ADDR_W)) u_init (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );
  assign acc    = en & ~init_busy;
  assign wa     = clr_we ? clr_addr : addr;
  assign wd     = clr_we ? '0 : d;
  assign wl     = clr_we ? '1 : ((acc & ~wen) ? be : '0);
  assign rd_old = mem[addr];
  // write-through merges only the lanes being written this cycle
  always_comb begin
    rd_word = rd_old;
    for (int i = 0; i < NUM_LANES; i++)
      if (RDW_MODE != 0 && !clr_we && wl[i]) rd_word[8*i +: 8] = d[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (wl[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= acc;
      if (acc) q <= rd_word;
    end
  end
`ifdef SRAM_PARITY_EN
  logic [NUM_LANES-1:0] pmem [DEPTH];
  logic [NUM_LANES-1:0] pw, pr, pc;
  always_comb begin
    pr = pmem[addr];
    pw = '0;
    pc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pw[i] = parity(wd[8*i +: 8]) ^ (par_inj & ~clr_we);
      if (RDW_MODE != 0 && !clr_we && wl[i]) pr[i] = pw[i];
      pc[i] = parity(rd_word[8*i +: 8]);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (wl[i]) pmem[wa][i] <= pw[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err <= 1'b0;
    else if (acc) par_err <= |(pr ^ pc);
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign par_err        = 1'b0;
`endif
endmodule

// File: tb/tb_sram_sp_param.sv
// tb_sram_sp_param: directed vectors on a read-first 32x1024 instance and a write-through 32x16 instance.
module tb_sram_sp_param;
  logic clk, rst, en, wen, pi;
  logic [3:0]  be;
  logic [9:0]  addr;
  logic [31:0] d, qa, qb;
  logic qva, qvb, pea, peb, iba, ibb;
  int checks = 0, errors = 0;
  typedef struct {
    logic en, wen;
    logic [3:0] be;
    logic [9:0] addr;
    logic [31:0] d, ea, eb;
    logic ev;
  } vec_t;
  vec_t v[16];
  sram_sp_param #(.DATA_W(32), .ADDR_W(10), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr), .d(d),
    .par_inj(pi), .q(qa), .q_valid(qva), .par_err(pea), .init_busy(iba)
  );
  sram_sp_param #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr[3:0]), .d(d),
    .par_inj(pi), .q(qb), .q_valid(qvb), .par_err(peb), .init_busy(ibb)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic access(input logic e, input logic w, input logic [3:0] b, input logic [9:0] a,
                        input logic [31:0] dd);
    en = e; wen = w; be = b; addr = a; d = dd;
    @(posedge clk); #1;
    en = 1'b0; wen = 1'b1; be = '0;
  endtask
  task automatic wait_clear(input string tag);
    int na, nb;
    logic seen_v;
    na = 0; nb = 0; seen_v = 1'b0;
    for (int k = 1; k <= 1100 && na == 0; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin en = 1'b0; wen = 1'b1; be = '0; end
      if (nb == 0 && ibb) seen_v = seen_v | qvb | (qb != 0);
      if (na == 0 && iba) seen_v = seen_v | qva | (qa != 0);
      if (nb == 0 && !ibb) nb = k;
      if (na == 0 && !iba) na = k;
    end
    chk({tag, "_b_init_cycles"}, nb, 16);
    chk({tag, "_a_init_cycles"}, na, 1024);
    chk({tag, "_quiet_during_init"}, {31'd0, seen_v}, 0);
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b1, 4'hF, 10'h003, 32'h0,        32'h0,        32'h0,        1'b1};
    v[1]  = '{1'b1, 1'b1, 4'hF, 10'h3FF, 32'h0,        32'h0,        32'h0,        1'b1};
    v[2]  = '{1'b1, 1'b0, 4'hF, 10'h3FF, 32'hA5,       32'h0,        32'hA5,       1'b1};
    v[3]  = '{1'b1, 1'b1, 4'h0, 10'h3FF, 32'h0,        32'hA5,       32'hA5,       1'b1};
    v[4]  = '{1'b0, 1'b1, 4'h0, 10'h000, 32'h0,        32'hA5,       32'hA5,       1'b0};
    v[5]  = '{1'b1, 1'b0, 4'hF, 10'h005, 32'h11223344, 32'h0,        32'h11223344, 1'b1};
    v[6]  = '{1'b1, 1'b0, 4'h5, 10'h005, 32'hAABBCCDD, 32'h11223344, 32'h11BB33DD, 1'b1};
    v[7]  = '{1'b1, 1'b1, 4'h0, 10'h005, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 1'b1};
    v[8]  = '{1'b1, 1'b0, 4'h0, 10'h005, 32'hFFFFFFFF, 32'h11BB33DD, 32'h11BB33DD, 1'b1};
    v[9]  = '{1'b1, 1'b1, 4'h0, 10'h005, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 1'b1};
    v[10] = '{1'b1, 1'b0, 4'hF, 10'h006, 32'h11223344, 32'h0,        32'h11223344, 1'b1};
    v[11] = '{1'b1, 1'b0, 4'h5, 10'h006, 32'hAABBCCDD, 32'h11223344, 32'h11BB33DD, 1'b1};
    v[12] = '{1'b1, 1'b1, 4'h0, 10'h015, 32'h0,        32'h0,        32'h11BB33DD, 1'b1};
    v[13] = '{1'b1, 1'b1, 4'hF, 10'h3FF, 32'hFFFFFFFF, 32'hA5,       32'hA5,       1'b1};
    v[14] = '{1'b0, 1'b0, 4'hF, 10'h3FF, 32'hFFFFFFFF, 32'hA5,       32'hA5,       1'b0};
    v[15] = '{1'b1, 1'b1, 4'h0, 10'h3FF, 32'h0,        32'hA5,       32'hA5,       1'b1};
    rst = 1'b1; en = 1'b0; wen = 1'b1; be = '0; addr = '0; d = '0; pi = 1'b0;
    #3;
    chk("rst_q", {qa[15:0], qb[15:0]}, 0);
    chk("rst_flags", {26'd0, qva, qvb, pea, peb, iba, ibb}, 32'h3);
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b1; wen = 1'b0; be = 4'hF; addr = 10'h003; d = 32'hFFFFFFFF;
    wait_clear("first");
    for (int i = 0; i < 16; i++) begin
      access(v[i].en, v[i].wen, v[i].be, v[i].addr, v[i].d);
      chk($sformatf("vec%0d_qa", i), qa, v[i].ea);
      chk($sformatf("vec%0d_qb", i), qb, v[i].eb);
      chk($sformatf("vec%0d_valid", i), {30'd0, qva, qvb}, {30'd0, v[i].ev, v[i].ev});
`ifndef SRAM_PARITY_EN
      chk($sformatf("vec%0d_par", i), {30'd0, pea, peb}, 0);
`endif
    end
    rst = 1'b1; #1;
    chk("ready_rst_async", {qa[15:0], qb[15:0]}, 0);
    chk("ready_rst_flags", {28'd0, qva, qvb, iba, ibb}, 32'h3);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("mid_init_rst", {29'd0, qvb, ibb, qb != 0}, 32'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear("restart");
    access(1'b1, 1'b1, 4'h0, 10'h3FF, 32'h0);
    chk("rezero_3ff", {qa[15:0], qb[15:0]}, 0);
    chk("rezero_3ff_valid", {30'd0, qva, qvb}, 32'h3);
    access(1'b1, 1'b1, 4'h0, 10'h005, 32'h0);
    chk("rezero_005_a", qa, 0);
    chk("rezero_005_b", qb, 0);
`ifdef SRAM_PARITY_EN
    access(1'b1, 1'b0, 4'hF, 10'h3FE, 32'h5A);
    access(1'b1, 1'b1, 4'h0, 10'h3FE, 32'h0);
    chk("par_clean_q", qa, 32'h5A);
    chk("par_clean_err", {30'd0, pea, peb}, 0);
    pi = 1'b1;
    access(1'b1, 1'b0, 4'hF, 10'h3FD, 32'h5A);
    pi = 1'b0;
    access(1'b1, 1'b1, 4'h0, 10'h3FD, 32'h0);
    chk("par_inj_q", {qa[15:0], qb[15:0]}, 32'h005A005A);
    chk("par_inj_err", {30'd0, pea, peb}, 32'h3);
`else
    pi = 1'b1;
    access(1'b1, 1'b0, 4'hF, 10'h3FD, 32'h5A);
    pi = 1'b0;
    access(1'b1, 1'b1, 4'h0, 10'h3FD, 32'h0);
    chk("nopar_q", qa, 32'h5A);
    chk("nopar_err", {30'd0, pea, peb}, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
